ram_burst_reader: RTL and testbench
===================================

RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width of RAM read data and output stream.
REQ-002 Parameter ADDR_WIDTH, default 10, RAM address width.
REQ-003 Parameter LEN_WIDTH, default ADDR_WIDTH+1, width of burst length; max length 2^ADDR_WIDTH words.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cmd_valid  input  1  burst command present.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_addr  input  ADDR_WIDTH  first word address.
REQ-009 cmd_len  input  LEN_WIDTH  number of words to read.
REQ-010 ram_en  output  1  RAM read-port enable, read-only port, no write.
REQ-011 ram_addr  output  ADDR_WIDTH  RAM read address.
REQ-012 ram_dout  input  DATA_WIDTH  RAM read data, valid the cycle after ram_en.
REQ-013 out_valid  output  1  output word present.
REQ-014 out_ready  input  1  consumer accepts word.
REQ-015 out_data  output  DATA_WIDTH  output word.
REQ-016 out_last  output  1  marks final word of burst, qualified by out_valid.
REQ-017 busy  output  1  burst in progress or words buffered.

Function
REQ-018 FSM states: IDLE, ISSUE, DRAIN; IDLE->ISSUE on cmd handshake with cmd_len>0; ISSUE->DRAIN after last read issued; DRAIN->IDLE when buffer empty and no read in flight.
REQ-019 cmd_ready is high only in IDLE; a handshake is cmd_valid&&cmd_ready at a rising edge.
REQ-020 cmd_len==0 is accepted, produces no ram_en and no output, and the block stays in IDLE.
REQ-021 Read issue: ram_en high in a cycle iff state is ISSUE and (buffered words + in-flight reads) < 2; ram_addr increments by 1 per issued read.
REQ-022 Address arithmetic is modulo 2^ADDR_WIDTH; 0x3FF+1 wraps to 0x000.
REQ-023 Reads issued per burst equal cmd_len exactly; ram_en is low outside ISSUE.
REQ-024 ram_dout is captured into a 2-entry output FIFO the cycle after each issued read; no word is dropped or duplicated under any out_ready pattern.
REQ-025 Latency: handshake at edge N -> ram_en in cycle N+1 -> first out_valid in cycle N+3.
REQ-026 With out_ready held high, throughput is one word per cycle after first word.
REQ-027 out_valid, out_data, out_last hold stable while out_valid&&!out_ready.
REQ-028 out_last asserted with the cmd_len-th word only; a 1-word burst has out_last on its only word.
REQ-029 Simultaneous FIFO push and pop when FIFO is full is legal and keeps occupancy at 2.
REQ-030 busy = (state != IDLE).

Reset
REQ-031 On rst assertion, asynchronously: state IDLE, cmd_ready 1 after release, ram_en 0, ram_addr 0, out_valid 0, out_last 0, out_data 0, busy 0, FIFO empty, counters 0.
REQ-032 rst mid-burst aborts the burst; in-flight RAM data returning after reset is discarded.

Structure
REQ-033 Shared package rd_pkg holds the FSM state enum and the FIFO depth constant (2).
REQ-034 The output FIFO is sub-module fifo2 (DATA_WIDTH+1 wide, carrying out_last), same clk/rst.

Verification
REQ-035 addr=0x010, len=4, out_ready=1, RAM preloaded mem[i]=i -> out_data 0x10,0x11,0x12,0x13 on four consecutive cycles starting N+3, out_last on 0x13.
REQ-036 addr=0x3FE, len=4 -> ram_addr sequence 0x3FE,0x3FF,0x000,0x001; outputs match mem contents.
REQ-037 len=8, out_ready toggled 1,0,0,1 random -> all 8 words in order, none lost/duplicated, ram_en never issues when buffer+in-flight=2.
REQ-038 len=0 -> no ram_en, no out_valid, cmd_ready high next cycle.
REQ-039 len=1 -> single word with out_last=1, busy falls after pop.
REQ-040 rst asserted mid-burst of len=16 -> all outputs to reset values immediately; new command addr=0x020, len=2 after release yields exactly mem[0x20], mem[0x21].

Source files
------------

// File: rtl/rd_pkg.sv
// Shared definitions for the RAM burst reader: FSM state encoding and the
// depth of the small output FIFO that decouples RAM latency from the consumer.
package rd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  localparam logic [1:0] FIFO_DEPTH = 2'd2;

endpackage

// File: rtl/fifo2.sv
// Two-entry output FIFO. The head entry is presented combinationally, so it
// stays stable while the consumer stalls; push and pop may coincide when full.
module fifo2
  import rd_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot in the same cycle, which lets a full FIFO accept a push.
  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != FIFO_DEPTH) || do_pop);

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Streams a burst of consecutive RAM words to a valid/ready consumer, issuing
// reads only while the output FIFO plus reads in flight leave room for the data.
module ram_burst_reader
  import rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [LEN_WIDTH-1:0]  remaining_d;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic [1:0]            fifo_count;
  logic [2:0]            slots;
  logic                  pop;
  logic                  cmd_fire;
  logic                  issue_last;
  logic [DATA_WIDTH:0]   fifo_head;

  assign cmd_ready = (state_q == ST_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign busy      = (state_q != ST_IDLE);
  assign pop       = out_valid && out_ready;

  // A word leaving this cycle frees its slot, which keeps full throughput
  // while never letting buffered plus in-flight words exceed the FIFO depth.
  assign slots      = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign ram_en     = (state_q == ST_ISSUE) && (slots < 3'd2);
  assign ram_addr   = addr_q;
  assign issue_last = ram_en && (remaining_q == LEN_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire && (cmd_len != '0)) begin
          state_d     = ST_ISSUE;
          addr_d      = cmd_addr;
          remaining_d = cmd_len;
        end
      end
      ST_ISSUE: begin
        if (ram_en) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (issue_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((fifo_count == 2'd0) && !inflight_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clearing inflight_q on reset discards RAM data from an aborted burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= ram_en;
      inflight_last_q <= issue_last;
    end
  end

  fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inflight_q),
    .push_data_i({inflight_last_q, ram_dout}),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .valid_o    (out_valid),
    .count_o    (fifo_count)
  );

  assign out_data = fifo_head[DATA_WIDTH-1:0];
  assign out_last = fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: a behavioural RAM with mem[i]=i, and a
// scoreboard of expected read addresses and output words filled at each command.
module tb_ram_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic        ram_en;
  logic [9:0]  ram_addr;
  logic [31:0] ram_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  logic [31:0] mem [1024];
  logic [32:0] expData[$];
  logic [9:0]  expAddr[$];

  int assertCnt = 0;
  int failCnt   = 0;
  int issuedCnt = 0;
  int poppedCnt = 0;
  logic        prevStall = 1'b0;
  logic [32:0] prevWord  = '0;

  ram_burst_reader dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .ram_en   (ram_en),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) ram_dout <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCnt++;
    assert (observed === expected) else begin
      failCnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] addr, input logic [10:0] len);
    int waitCyc = 0;
    logic [9:0] a;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    while (!cmd_ready && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("cmdReady", cmd_ready, 1);
    for (int i = 0; i < int'(len); i++) begin
      a = addr + 10'(i);
      expAddr.push_back(a);
      expData.push_back({(i == int'(len) - 1), mem[a]});
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((expData.size() != 0 || busy) && n < 300);
    checkOutput(tag, {expData.size() == 0, busy}, 2'b10);
  endtask

  // Monitor: read addresses, issue limit, stall stability and delivered words.
  always @(negedge clk) begin
    if (!rst) begin
      if (prevStall) begin
        checkOutput("holdValid", out_valid, 1);
        checkOutput("holdWord", {out_last, out_data}, prevWord);
      end
      if (ram_en) begin
        checkOutput("issueLimit", (issuedCnt - poppedCnt - ((out_valid && out_ready) ? 1 : 0)) < 2, 1);
        if (expAddr.size() > 0) checkOutput("ramAddr", ram_addr, expAddr.pop_front());
        else checkOutput("readsPending", expAddr.size(), 1);
      end
      if (out_valid && out_ready) begin
        if (expData.size() > 0) checkOutput("outWord", {out_last, out_data}, expData.pop_front());
        else checkOutput("wordsPending", expData.size(), 1);
      end
      issuedCnt += ram_en ? 1 : 0;
      poppedCnt += (out_valid && out_ready) ? 1 : 0;
      prevStall  = out_valid && !out_ready;
      prevWord   = {out_last, out_data};
    end
  end

  initial begin
    logic [3:0] pat;
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rstRamEn", ram_en, 0);
    checkOutput("rstRamAddr", ram_addr, 0);
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstOutLast", out_last, 0);
    checkOutput("rstOutData", out_data, 0);
    checkOutput("rstBusy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstCmdReady", cmd_ready, 1);

    $display("[TB] burst addr=0x010 len=4, consumer always ready");
    out_ready = 1'b1;
    applyStimulus(10'h010, 11'd4);
    @(negedge clk);
    checkOutput("latRamEn", ram_en, 1);
    checkOutput("latRamAddr", ram_addr, 10'h010);
    checkOutput("latBusy", busy, 1);
    checkOutput("latCmdReady", cmd_ready, 0);
    @(negedge clk);
    checkOutput("latNoValidYet", out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("streamValid", out_valid, 1);
      checkOutput("streamData", out_data, 32'h10 + 32'(k));
      checkOutput("streamLast", out_last, (k == 3));
    end
    @(negedge clk);
    checkOutput("streamEnd", out_valid, 0);
    waitIdle("idleAfterLen4");

    $display("[TB] burst addr=0x3FE len=4, address wrap");
    applyStimulus(10'h3FE, 11'd4);
    waitIdle("idleAfterWrap");

    $display("[TB] burst len=8 with stalling consumer");
    pat = 4'b1001;
    applyStimulus(10'h123, 11'd8);
    n = 0;
    while (expData.size() > 0 && n < 400) begin
      @(posedge clk);
      #1;
      out_ready = (n < 4) ? pat[3 - n] : 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b1;
    waitIdle("idleAfterStall");

    $display("[TB] zero-length command");
    applyStimulus(10'h055, 11'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("len0RamEn", ram_en, 0);
      checkOutput("len0OutValid", out_valid, 0);
      checkOutput("len0CmdReady", cmd_ready, 1);
      checkOutput("len0Busy", busy, 0);
    end

    $display("[TB] single-word burst");
    applyStimulus(10'h03A, 11'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    checkOutput("len1Word", {out_valid, out_last, out_data}, {2'b11, 32'h3A});
    repeat (2) @(negedge clk);
    checkOutput("len1BusyFall", {busy, cmd_ready, out_valid}, 3'b010);
    waitIdle("idleAfterLen1");

    $display("[TB] reset in the middle of a len=16 burst");
    applyStimulus(10'h100, 11'd16);
    repeat (6) @(negedge clk);
    #1;
    rst = 1'b1;
    expData.delete();
    expAddr.delete();
    issuedCnt = 0;
    poppedCnt = 0;
    prevStall = 1'b0;
    #1;
    checkOutput("midRstRamEn", ram_en, 0);
    checkOutput("midRstRamAddr", ram_addr, 0);
    checkOutput("midRstOut", {out_valid, out_last, out_data}, 34'd0);
    checkOutput("midRstBusy", busy, 0);
    #1;
    rst = 1'b0;
    applyStimulus(10'h020, 11'd2);
    waitIdle("idleAfterRst");
    repeat (5) @(negedge clk);
    checkOutput("noStrayWords", poppedCnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
